// File: rtl/mskreg_fifo.sv
// mskreg_fifo: FIFO of masked words, with a configurable depth.
// Each entry holds count*d share bits. Shares are stored and forwarded
// bit-for-bit, and no logic ever combines bits of different shares.
// Optional clear-on-pop zeroes each vacated slot, so that stale shares do
// not stay behind in storage.
module mskreg_fifo #(
    parameter int d            = 2,
    parameter int count        = 1,
    parameter int depth        = 2,
    parameter bit clear_on_pop = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [count*d-1:0]           in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [count*d-1:0]           out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(depth+1)-1:0]   level
);

    localparam int W  = count * d;
    localparam int PW = (depth > 1) ? $clog2(depth) : 1;
    localparam int LW = $clog2(depth + 1);

    // Pointers wrap on an explicit compare, so a non-power-of-two depth
    // never visits an unused slot.
    localparam logic [PW-1:0] PTR_LAST = PW'(depth - 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(depth);

    // Masked storage. It is kept out of optimisation so that synthesis
    // cannot merge or restructure share bits across entries.
    (* keep = "true", dont_touch = "true" *)
    logic [W-1:0]  mem [depth];

    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic          push;
    logic          pop;

    // Handshake flags come only from the registered level. There is no
    // path from out_ready to in_ready.
    assign in_ready  = (level != LVL_FULL);
    assign out_valid = (level != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // The head word is a plain register read. Each bit comes straight
    // from its own storage bit.
    assign out_data  = mem[rp];

    // Write pointer: advance on every accepted word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp <= '0;
        end else if (push) begin
            wp <= (wp == PTR_LAST) ? '0 : wp + PW'(1);
        end
    end

    // Read pointer: advance on every consumed word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rp <= '0;
        end else if (pop) begin
            rp <= (rp == PTR_LAST) ? '0 : rp + PW'(1);
        end
    end

    // Occupancy: level is unchanged when a push and a pop happen together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= '0;
        end else begin
            unique case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage: each slot decodes its own write and clear. A simultaneous
    // push and pop can only happen when 0 < level < depth, so then wp != rp
    // and the two never hit the same slot. The push is listed last anyway.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < depth; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < depth; i++) begin
                if (clear_on_pop && pop && (rp == PW'(i))) begin
                    mem[i] <= '0;
                end
                if (push && (wp == PW'(i))) begin
                    mem[i] <= in_data;
                end
            end
        end
    end

endmodule
